// File: rtl/gsum_multi.sv
// gsum_multi
//   Sums the non-negative elements of a banked element store.
//   Elements are interleaved across LANES single-port banks: element i lives in
//   bank i % LANES, row i / LANES. A run reads one row per cycle and adds every
//   lane whose index is below n and whose sign bit is clear.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous, active-low reset
//   start       level request to begin a sum (accepted only in IDLE)
//   n           element count, sampled on acceptance, clamped to DEPTH
//   wr_en       element write strobe (honoured only in IDLE or DONE)
//   wr_addr     element write address
//   wr_data     element write data
//   busy        high from acceptance until finish rises
//   finish      result valid; held while start stays high
//   return_val  sum of non-negative elements (retained after finish drops)
//
// Configuration
//   GSUM_SATURATE_EN  when defined, the accumulator saturates at the largest
//                     positive ACC_W value; otherwise it wraps modulo 2^ACC_W.

module gsum_multi #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int DEPTH  = 1024,
    parameter int LANES  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     busy,
    output logic                     finish,
    output logic [ACC_W-1:0]         return_val
);

    localparam int AW   = $clog2(DEPTH);
    localparam int LB   = $clog2(LANES);
    localparam int ROWS = DEPTH / LANES;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
`ifdef GSUM_SATURATE_EN
    // Extra headroom so a full row of maximum values cannot wrap before clamping.
    localparam int SW = ACC_W + 4;
`else
    localparam int SW = ACC_W;
`endif

    typedef enum logic [2:0] {IDLE, RUN, DRAIN1, DRAIN2, DONE} state_t;

    state_t                      state;
    state_t                      state_next;
    logic [AW:0]                 n_clamped;
    logic [AW:0]                 k_rows;
    logic [AW:0]                 n_lat;
    logic [AW:0]                 rows_left;
    logic [RW-1:0]               row_ptr;
    logic [RW-1:0]               rd_row;
    logic [RW-1:0]               bank_addr;
    logic [RW-1:0]               wr_row;
    logic                        accept;
    logic                        wr_ok;
    logic                        rd_valid;
    logic                        sum_valid;
    logic [LANES-1:0][DATA_W-1:0] rd_data;
    logic [SW-1:0]               lane_sum;
    logic [SW-1:0]               sum_q;
    logic [ACC_W-1:0]            acc;
    logic [ACC_W-1:0]            acc_next;

    assign accept    = (state == IDLE) && start;
    assign n_clamped = (n > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : n;
    assign k_rows    = (n_clamped + (AW+1)'(LANES - 1)) >> LB;

    // Writes are only honoured while no run owns the bank ports.
    assign wr_ok     = wr_en && ((state == IDLE) || (state == DONE));
    assign wr_row    = RW'(wr_addr >> LB);
    assign bank_addr = (state == RUN) ? row_ptr : wr_row;

    // One single-port bank per lane with a registered read.
    for (genvar g = 0; g < LANES; g++) begin : g_bank
        logic [DATA_W-1:0] mem [ROWS];
        logic [DATA_W-1:0] rd_q;
        logic              bank_we;

        assign bank_we = wr_ok && ((int'(wr_addr) % LANES) == g);

        always_ff @(posedge clk) begin
            if (bank_we) begin
                mem[bank_addr] <= wr_data;
            end
            rd_q <= mem[bank_addr];
        end

        assign rd_data[g] = rd_q;
    end

    // Lanes past the requested count, and negative elements, contribute nothing.
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            if (rd_valid && ((((AW+1)'(rd_row) << LB) + (AW+1)'(l)) < n_lat)
                && !rd_data[l][DATA_W-1]) begin
                lane_sum = lane_sum + SW'(signed'(rd_data[l]));
            end
        end
    end

`ifdef GSUM_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    logic [SW-1:0] acc_wide;

    // Every term is non-negative, so only the positive limit can be crossed.
    always_comb begin
        acc_wide = SW'(acc) + sum_q;
        acc_next = (acc_wide > SW'(ACC_MAX)) ? ACC_MAX : acc_wide[ACC_W-1:0];
    end
`else
    assign acc_next = acc + sum_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE lingers until finish has been raised and start has been dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (n_clamped == '0) ? DRAIN1 : RUN;
            RUN:     if (rows_left == (AW+1)'(1)) state_next = DRAIN1;
            DRAIN1:  state_next = DRAIN2;
            DRAIN2:  state_next = DONE;
            DONE:    if (finish && !start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read pipeline -> registered lane adder -> accumulator -> result register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_lat      <= '0;
            rows_left  <= '0;
            row_ptr    <= '0;
            rd_row     <= '0;
            rd_valid   <= 1'b0;
            sum_q      <= '0;
            sum_valid  <= 1'b0;
            acc        <= '0;
            busy       <= 1'b0;
            finish     <= 1'b0;
            return_val <= '0;
        end else begin
            rd_valid  <= (state == RUN);
            rd_row    <= row_ptr;
            sum_valid <= rd_valid;
            sum_q     <= lane_sum;

            if (accept) begin
                n_lat     <= n_clamped;
                rows_left <= k_rows;
                row_ptr   <= '0;
                acc       <= '0;
                busy      <= 1'b1;
            end else begin
                if (state == RUN) begin
                    row_ptr   <= row_ptr + 1'b1;
                    rows_left <= rows_left - 1'b1;
                end
                if (sum_valid) begin
                    acc <= acc_next;
                end
            end

            if ((state == DONE) && !finish) begin
                finish     <= 1'b1;
                busy       <= 1'b0;
                return_val <= acc;
            end else if ((state == DONE) && !start) begin
                finish <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gsum_multi.sv
// tb_gsum_multi
//   Self-checking bench for gsum_multi. Instance a uses the default geometry,
//   instance b uses LANES=1, DEPTH=16. Expected sums come from plain-arithmetic
//   reference arrays mirroring what has been written into each instance.

module tb_gsum_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [10:0] n_a;
    logic [4:0]  n_b;
    logic        wr_en_a, wr_en_b;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy_a, finish_a, busy_b, finish_b;
    logic [31:0] rv_a, rv_b;

    logic        obs_busy, obs_fin;
    logic [31:0] obs_rv;
    int          sel = 0;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [16];

    always #5 clk = ~clk;

    gsum_multi dut_a (
        .clk        (clk),
        .reset      (reset),
        .start      (start_a),
        .n          (n_a),
        .wr_en      (wr_en_a),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy_a),
        .finish     (finish_a),
        .return_val (rv_a)
    );

    gsum_multi #(.DATA_W(32), .ACC_W(32), .DEPTH(16), .LANES(1)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .start      (start_b),
        .n          (n_b),
        .wr_en      (wr_en_b),
        .wr_addr    (wr_addr[3:0]),
        .wr_data    (wr_data),
        .busy       (busy_b),
        .finish     (finish_b),
        .return_val (rv_b)
    );

    assign obs_busy = (sel != 0) ? busy_b : busy_a;
    assign obs_fin  = (sel != 0) ? finish_b : finish_a;
    assign obs_rv   = (sel != 0) ? rv_b : rv_a;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: sum of the first min(n, depth) elements that are non-negative.
    function automatic logic [31:0] model_sum(int inst, int nv);
        int              depth = (inst != 0) ? 16 : 1024;
        int              cnt   = (nv > depth) ? depth : nv;
        longint unsigned acc   = 0;
        logic [31:0]     v;
        for (int i = 0; i < cnt; i++) begin
            v = (inst != 0) ? mem_b[i] : mem_a[i];
            if (!v[31]) begin
                acc = acc + 64'(v);
`ifdef GSUM_SATURATE_EN
                if (acc > 64'h7FFF_FFFF) acc = 64'h7FFF_FFFF;
`else
                acc = acc & 64'hFFFF_FFFF;
`endif
            end
        end
        return acc[31:0];
    endfunction

    task automatic write_elem(input int inst, input int addr, input logic [31:0] data);
        wr_addr = 10'(addr);
        wr_data = data;
        if (inst != 0) begin
            wr_en_b     = 1'b1;
            mem_b[addr] = data;
        end else begin
            wr_en_a     = 1'b1;
            mem_a[addr] = data;
        end
        @(posedge clk); #1;
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
    endtask

    // One complete run: accept, wait for finish, hold start, then release.
    task automatic applyStimulus(input int inst, input int nv, input bit drop_writes, input string tag);
        int          depth;
        int          lanes;
        int          cnt;
        int          exp_lat;
        int          lat;
        logic [31:0] exp;
        sel     = inst;
        depth   = (inst != 0) ? 16 : 1024;
        lanes   = (inst != 0) ? 1 : 4;
        cnt     = (nv > depth) ? depth : nv;
        exp_lat = (cnt + lanes - 1) / lanes + 3;
        exp     = model_sum(inst, nv);
        if (inst != 0) begin
            start_b = 1'b1;
            n_b     = 5'(nv);
        end else begin
            start_a = 1'b1;
            n_a     = 11'(nv);
        end
        @(posedge clk); #1;
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        n_a     = 11'($urandom);
        n_b     = 5'($urandom);
        checkOutput({tag, ".busy_on"}, 64'(obs_busy), 64'd1);
        checkOutput({tag, ".fin_low"}, 64'(obs_fin), 64'd0);
        lat = 0;
        while (!obs_fin && lat < exp_lat + 10) begin
            if (drop_writes && lat <= exp_lat - 2) begin
                wr_addr = 10'($urandom_range(0, depth - 1));
                wr_data = $urandom;
                if (inst != 0) wr_en_b = 1'($urandom_range(0, 1));
                else           wr_en_a = 1'($urandom_range(0, 1));
            end else begin
                wr_en_a = 1'b0;
                wr_en_b = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        checkOutput({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, ".sum"}, 64'(obs_rv), 64'(exp));
        checkOutput({tag, ".busy_off"}, 64'(obs_busy), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput({tag, ".fin_hold"}, 64'(obs_fin), 64'd1);
            checkOutput({tag, ".rv_hold"}, 64'(obs_rv), 64'(exp));
            checkOutput({tag, ".no_rerun"}, 64'(obs_busy), 64'd0);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        @(posedge clk); #1;
        checkOutput({tag, ".fin_drop"}, 64'(obs_fin), 64'd0);
        checkOutput({tag, ".rv_kept"}, 64'(obs_rv), 64'(exp));
    endtask

    initial begin
        logic [31:0] exp24;
        int          nv;
        start_a = 1'b0;
        start_b = 1'b0;
        n_a     = '0;
        n_b     = '0;
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        reset   = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.busy", 64'(busy_a), 64'd0);
        checkOutput("rst.fin", 64'(finish_a), 64'd0);
        checkOutput("rst.rv", 64'(rv_a), 64'd0);
        checkOutput("rst.rv_b", 64'(rv_b), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 1024; i++) write_elem(0, i, 32'(i));
        for (int i = 0; i < 16; i++)   write_elem(1, i, 32'd1);

        applyStimulus(0, 1000, 1'b0, "ramp1000");
        checkOutput("ramp1000.const", 64'(rv_a), 64'd499500);

        // Reset in the middle of a run abandons it at once.
        sel     = 0;
        start_a = 1'b1;
        n_a     = 11'd1000;
        @(posedge clk); #1;
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("midrst.busy", 64'(busy_a), 64'd0);
        checkOutput("midrst.fin", 64'(finish_a), 64'd0);
        checkOutput("midrst.rv", 64'(rv_a), 64'd0);
        start_a = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        applyStimulus(0, 1000, 1'b1, "rerun1000");
        checkOutput("rerun1000.const", 64'(rv_a), 64'd499500);

        write_elem(0, 0, 32'd5);
        write_elem(0, 1, -32'sd3);
        write_elem(0, 2, 32'd7);
        write_elem(0, 3, -32'sd1);
        write_elem(0, 4, 32'd0);
        write_elem(0, 5, 32'd2);
        write_elem(0, 6, -32'sd8);
        write_elem(0, 7, 32'd4);
        applyStimulus(0, 6, 1'b0, "mix6");
        checkOutput("mix6.const", 64'(rv_a), 64'd14);
        applyStimulus(0, 0, 1'b0, "empty");

        for (int i = 0; i < 4; i++) write_elem(0, i, 32'h7FFF_FFFF);
`ifdef GSUM_SATURATE_EN
        exp24 = 32'h7FFF_FFFF;
`else
        exp24 = 32'hFFFF_FFFC;
`endif
        applyStimulus(0, 4, 1'b0, "bigvals");
        checkOutput("bigvals.const", 64'(rv_a), 64'(exp24));

        // Write on the accept edge must be seen by that run.
        wr_addr   = 10'd1;
        wr_data   = 32'd100;
        wr_en_a   = 1'b1;
        mem_a[1]  = 32'd100;
        applyStimulus(0, 3, 1'b0, "wr_on_start");

        applyStimulus(1, 20, 1'b1, "clamp16");
        checkOutput("clamp16.const", 64'(rv_b), 64'd16);
        applyStimulus(1, 16, 1'b0, "clamp16_again");

        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < 4; w++) begin
                write_elem(0, $urandom_range(0, 40),
                           ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 5000)));
            end
            write_elem(1, $urandom_range(0, 15), 32'($urandom_range(0, 9)));
            nv = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2047) : $urandom_range(0, 13);
            applyStimulus(0, nv, 1'($urandom_range(0, 1)), $sformatf("rnd_a%0d", r));
            applyStimulus(1, $urandom_range(0, 31), 1'($urandom_range(0, 1)), $sformatf("rnd_b%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gsum_multi.md
GSUM_MULTI -- requirements
Module: gsum_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 32: signed element width.
REQ-002 SHALL have parameter ACC_W, default 32: signed accumulator and result width, ACC_W >= DATA_W.
REQ-003 SHALL have parameter DEPTH, default 1024: element storage depth, power of two, multiple of LANES.
REQ-004 SHALL have parameter LANES, default 4: elements consumed per cycle, one of 1, 2, 4, 8.
REQ-005 SHALL have ports in this order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level request to begin a sum.
- n  in  $clog2(DEPTH)+1  element count, sampled with start.
- wr_en  in  1  element write strobe.
- wr_addr  in  $clog2(DEPTH)  element write address.
- wr_data  in  DATA_W  element write data.
- busy  out  1  high from accept until finish.
- finish  out  1  result valid.
- return_val  out  ACC_W  sum of non-negative elements.

Function
REQ-006 SHALL store elements in LANES banks; element i in bank i mod LANES, row i / LANES; each bank SHALL be single-port, 1-cycle registered read.
REQ-007 SHALL use states IDLE, RUN, DRAIN1, DRAIN2, DONE.
REQ-008 IDLE: start=1 at edge T SHALL latch n (clamped to DEPTH), clear accumulator, raise busy; next state RUN if n>0, else DRAIN1.
REQ-009 RUN SHALL issue one row read per cycle for K = ceil(n/LANES) cycles, then go to DRAIN1.
REQ-010 Each returned row SHALL contribute lanes whose element index < n and whose value is >= 0 (sign bit clear), summed via a registered adder stage into the accumulator.
REQ-011 Elements, when summed, SHALL be sign-extended to ACC_W; the accumulator SHALL wrap modulo 2^ACC_W unless REQ-020 applies.
REQ-012 DRAIN1 then DRAIN2 SHALL flush the read and adder pipelines, one cycle each; DRAIN2 goes to DONE.
REQ-013 finish SHALL rise exactly at edge T+K+3, together with return_val; busy SHALL fall on the same edge.
REQ-014 DONE SHALL hold finish=1 and return_val stable while start=1; start=0 returns to IDLE with finish=0 and return_val retained.
REQ-015 wr_en SHALL write only in IDLE or DONE; a write in RUN or DRAIN SHALL be dropped.
REQ-016 start while busy SHALL be ignored; the n input SHALL be ignored outside acceptance.
REQ-017 A write and start on the same IDLE edge SHALL both take effect, and the write SHALL be visible to that run.

Reset
REQ-018 reset=0 SHALL asynchronously force IDLE, busy=0, finish=0, return_val=0, and accumulator 0; an in-flight run is abandoned.
REQ-019 Bank contents SHALL NOT be cleared by reset.

Configuration
REQ-020 Macro GSUM_SATURATE_EN defined: accumulator SHALL saturate at 2^(ACC_W-1)-1 and hold there for the run; undefined: accumulator wraps (REQ-011), and no saturation logic SHALL be present.

Verification
REQ-021 Defaults; write a[i]=i for i<1000, start with n=1000 -> finish at T+253, return_val=499500.
REQ-022 Defaults; a[0..7] = {5,-3,7,-1,0,2,-8,4}; n=6 -> return_val=14, finish at T+5; then n=0 -> return_val=0, finish at T+3.
REQ-023 Assert reset=0 mid-RUN of REQ-021 -> immediately busy=0, finish=0, return_val=0; rerun after release -> 499500.
REQ-024 Defaults; a[i]=0x7FFFFFFF for i<4, n=4 -> with GSUM_SATURATE_EN, 0x7FFFFFFF; without it, 0xFFFFFFFC.
REQ-025 LANES=1, DEPTH=16: a[i]=1, n=20 -> clamped to 16, return_val=16, finish at T+19; wr_en pulsed during RUN changes nothing.
REQ-026 Hold start=1 after finish -> finish held, no new run; drop start then raise it -> new run accepted.
